// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and helpers used by the memory stage.
package mips_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int DMEM_DEPTH      = 256;
  localparam int DMEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10
  } mem_size_e;

  localparam logic CTRL_REG_WRITE_DIS  = 1'b0;
  localparam logic CTRL_MEM_TO_REG_ALU = 1'b0;

  // Size code 2'b11 behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (size == MEM_SIZE_BYTE) return 1'b0;
    if (size == MEM_SIZE_HALF) return offset[0];
    return offset != 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the addressed lane(s) and extends them.
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] raw_word,
  input  logic [1:0]            byte_offset,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = raw_word[8*byte_offset +: 8];
    lane_half = byte_offset[1] ? raw_word[31:16] : raw_word[15:0];
    load_data = raw_word;
    case (mem_size)
      MEM_SIZE_BYTE: load_data = {{24{lane_byte[7] & ~mem_unsigned}}, lane_byte};
      MEM_SIZE_HALF: load_data = {{16{lane_half[15] & ~mem_unsigned}}, lane_half};
      default:       load_data = raw_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: 256-word data memory, byte-lane stores, aligned loads.
// Optional alignment checking is enabled with MEM_MISALIGN_CHECK_EN.
module mem_stage
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     alu_result_in,
  input  logic [DATA_WIDTH-1:0]     write_data_in,
  input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
  input  logic                      reg_write_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      mem_to_reg_in,
  input  logic [1:0]                mem_size_in,
  input  logic                      mem_unsigned_in,
  input  logic                      stall_in,
  input  logic [DMEM_ADDR_WIDTH-1:0] dbg_addr_in,
  output logic [DATA_WIDTH-1:0]     read_data_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [REG_ADDR_WIDTH-1:0] write_register_out,
  output logic                      reg_write_out,
  output logic                      mem_to_reg_out,
  output logic                      misalign_out,
  output logic [DATA_WIDTH-1:0]     dbg_data_out
);

  logic [DATA_WIDTH-1:0]      mem [DMEM_DEPTH];
  logic [DMEM_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]                 byte_off;
  logic [3:0]                 byte_en;
  logic [DATA_WIDTH-1:0]      store_word;
  logic [DATA_WIDTH-1:0]      load_data;
  logic                       misaligned;
  logic                       do_write;

  assign word_idx = alu_result_in[DMEM_ADDR_WIDTH+1:2];
  assign byte_off = alu_result_in[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = (mem_read_in | mem_write_in) & is_misaligned(mem_size_in, byte_off);
`else
  assign misaligned = 1'b0;
`endif

  // Store data is replicated across lanes so the enables alone select the target bytes.
  always_comb begin
    byte_en    = 4'b1111;
    store_word = write_data_in;
    case (mem_size_in)
      MEM_SIZE_BYTE: begin
        byte_en    = 4'b0001 << byte_off;
        store_word = {4{write_data_in[7:0]}};
      end
      MEM_SIZE_HALF: begin
        byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data_in[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_word = write_data_in;
      end
    endcase
  end

  assign do_write = mem_write_in & ~stall_in & ~reset & ~misaligned;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[word_idx][8*k +: 8] <= store_word[8*k +: 8];
      end
    end
  end

  load_align u_load_align (
    .raw_word     (mem[word_idx]),
    .byte_offset  (byte_off),
    .mem_size     (mem_size_in),
    .mem_unsigned (mem_unsigned_in),
    .load_data    (load_data)
  );

  // Load data is sampled before this edge's write lands, so a load sees the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_out      <= '0;
      alu_result_out     <= '0;
      write_register_out <= '0;
      reg_write_out      <= CTRL_REG_WRITE_DIS;
      mem_to_reg_out     <= CTRL_MEM_TO_REG_ALU;
    end else if (!stall_in) begin
      read_data_out      <= (mem_read_in && !mem_write_in && !misaligned) ? load_data : '0;
      alu_result_out     <= alu_result_in;
      write_register_out <= write_register_in;
      reg_write_out      <= misaligned ? CTRL_REG_WRITE_DIS : reg_write_in;
      mem_to_reg_out     <= mem_to_reg_in;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_out <= 1'b0;
    end else if (!stall_in) begin
      misalign_out <= misaligned;
    end
  end
`else
  assign misalign_out = 1'b0;
`endif

  assign dbg_data_out = mem[dbg_addr_in];

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 alu_result_in  input  32  effective byte address, or ALU value passed through to WB.
REQ-004 write_data_in  input  32  store data (rt value).
REQ-005 write_register_in  input  5  WB destination register.
REQ-006 reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  input  1 each  control bits from EX/MEM.
REQ-007 mem_size_in  input  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-008 mem_unsigned_in  input  1  zero-extend sub-word loads; sign-extend when 0.
REQ-009 stall_in  input  1  hold request: no memory write; all outputs hold.
REQ-010 dbg_addr_in  input  8  word index for the debug read port.
REQ-011 read_data_out  output  32  aligned and extended load data.
REQ-012 alu_result_out  output  32; write_register_out  output  5; reg_write_out, mem_to_reg_out  output  1: registered copies of the inputs for WB.
REQ-013 misalign_out  output  1  misaligned-access flag; tied 0 when the check is compiled out.
REQ-014 dbg_data_out  output  32  combinational read of mem[dbg_addr_in].

Function
REQ-015 Data memory: DMEM_DEPTH = 256 words of 32 bits, word index = alu_result_in[9:2]; higher address bits are ignored, so addresses wrap.
REQ-016 Byte lanes are little-endian: lane k = bits [8k+7:8k], with k selected by addr[1:0].
REQ-017 Byte store writes lane addr[1:0] with write_data_in[7:0]; half store writes lanes {addr[1],0} and {addr[1],1} with [15:0]; word store writes all lanes; other lanes are unchanged.
REQ-018 A store commits on the posedge where mem_write_in=1, stall_in=0 and reset=0.
REQ-019 Outputs register on every non-stalled posedge, giving one-cycle latency; read_data_out then reflects the memory contents before that edge's write.
REQ-020 Load extraction: byte = lane addr[1:0], half = addr[1] half; sign- or zero-extended per mem_unsigned_in; word = unmodified.
REQ-021 read_data_out = 0 when mem_read_in=0.
REQ-022 When mem_read_in=1 and mem_write_in=1 together, the write is performed and read_data_out = 0.
REQ-023 With stall_in=1: no write, all outputs hold their values, and inputs are ignored.
REQ-024 Back-to-back store then load to the same address on consecutive cycles: the load returns the stored value, with no hazard.

Reset
REQ-025 On reset: read_data_out, alu_result_out = 0; write_register_out = 0; reg_write_out = CTRL_REG_WRITE_DIS; mem_to_reg_out = CTRL_MEM_TO_REG_ALU; misalign_out = 0.
REQ-026 Reset takes precedence over stall_in and suppresses any store on the same edge.
REQ-027 Memory contents are not cleared by reset.
REQ-028 Reset mid-sequence drops the in-flight access; the next non-reset edge operates normally.

Configuration
REQ-029 Macro MEM_MISALIGN_CHECK_EN, defined:
- Misaligned access = half with addr[0]=1, or word/11 with addr[1:0]!=0, with mem_read_in or mem_write_in set.
- On a misaligned access: store suppressed, read_data_out = 0, reg_write_out = 0, misalign_out = 1 for that registered cycle only.
REQ-030 Macro undefined:
- Low address bits are ignored for alignment (half uses addr[1]; word ignores [1:0]).
- misalign_out is constant 0.

Structure
REQ-031 mips_pkg.vh holds DATA_WIDTH, REG_ADDR_WIDTH, DMEM_DEPTH, DMEM_ADDR_WIDTH, MEM_SIZE_BYTE/HALF/WORD, CTRL_REG_WRITE_DIS, CTRL_MEM_TO_REG_ALU.
REQ-032 Sub-module load_align (combinational) takes raw word, addr[1:0], size and unsigned, and outputs the 32-bit result; store byte-enable generation stays in mem_stage.

Verification
REQ-033 Word store 0xDEADBEEF @0x10, then word load @0x10 -> read_data_out = 0xDEADBEEF one cycle after the load is presented.
REQ-034 Byte store 0x80 @0x13 over that word, then signed byte load @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x80ADBEEF.
REQ-035 Half store 0x1234 @0x22, then signed half load @0x22 -> 0x00001234.
REQ-036 stall_in=1 with a store of 0x55 @0x40 -> mem unchanged (dbg_data_out) and outputs held; reset asserted with a store -> no write and all outputs at reset values.
REQ-037 Word load @0x402 -> with MEM_MISALIGN_CHECK_EN: misalign_out=1, reg_write_out=0, read_data_out=0; without it: returns the word at index 0x00 (0x400 wraps to index 0).
